// File: rtl/sb_generic_piped.sv
// N-sided routing switch block with a Wilton-style track twist, per-output constant-0 tie-off and optional output flop.
// Configuration arrives on a double-buffered scan chain; only a commit after an exact-length load reaches the muxes.
module sb_generic_piped #(
    parameter int CHANNEL_ONEWAY_WIDTH = 4,
    parameter int NUM_SIDES            = 4,
    parameter int TWIST                = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_SIDES*CHANNEL_ONEWAY_WIDTH-1:0] side_in,
    output logic [NUM_SIDES*CHANNEL_ONEWAY_WIDTH-1:0] side_out,
    input  logic                                      scan_in,
    input  logic                                      scan_en,
    output logic                                      scan_out,
    input  logic                                      cfg_commit,
    output logic                                      cfg_valid,
    output logic                                      cfg_err
);

    localparam int W        = CHANNEL_ONEWAY_WIDTH;
    localparam int N        = NUM_SIDES;
    localparam int NOUT     = N * W;
    localparam int SEL_W    = (N > 2) ? $clog2(N - 1) : 1;
    localparam int F        = SEL_W + 1;
    localparam int CFG_BITS = NOUT * F;
    localparam int CNT_W    = $clog2(CFG_BITS + 2);
    localparam int NSRC     = 2 ** SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFTING,
        ST_LOADED
    } state_e;

    state_e              state_q, state_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [NOUT-1:0]     pipe_q;
    logic [NOUT-1:0]     mux_out;
    logic [NOUT-1:0]     reg_en;

    logic commit_ok;
    logic load_active;
    logic set_err;
    logic clr_valid;

    // A commit is accepted only on an idle scan clock after exactly CFG_BITS shifts.
    assign commit_ok = cfg_commit && !scan_en && (cnt_q == CNT_W'(CFG_BITS));

    // ---------------- commit FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (cfg_commit) begin
            state_d = commit_ok ? ST_LOADED : ST_IDLE;
        end else if (scan_en) begin
            state_d = ST_SHIFTING;
        end
    end

    // ---------------- commit FSM: outputs ----------------
    always_comb begin
        load_active = commit_ok;
        set_err     = cfg_commit && !commit_ok;
        clr_valid   = scan_en && (state_q == ST_LOADED);
    end

    // ---------------- configuration datapath ----------------
    // NOTE: every signal gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        err_d    = err_q;

        if (scan_en) begin
            shadow_d = {scan_in, shadow_q[CFG_BITS-1:1]};
            if (cnt_q != CNT_W'(CFG_BITS + 1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A commit restarts the count; a shift in the same cycle counts as the first bit of a new load.
        if (cfg_commit) begin
            cnt_d = scan_en ? CNT_W'(1) : '0;
        end

        if (load_active) begin
            active_d = shadow_q;
            valid_d  = 1'b1;
        end else if (clr_valid) begin
            valid_d = 1'b0;
        end

        if (set_err) begin
            err_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            pipe_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            pipe_q   <= mux_out;
        end
    end

    // ---------------- routing muxes ----------------
    // Source k of output (s,i) is the k-th other side (ascending, skipping s), track (i + k*TWIST) mod W; TWIST >= 0.
    for (genvar s = 0; s < N; s++) begin : g_side
        for (genvar i = 0; i < W; i++) begin : g_trk
            localparam int OUT_IDX = s * W + i;

            logic [NSRC-1:0]  srcs;
            logic [SEL_W-1:0] sel;

            for (genvar k = 0; k < NSRC; k++) begin : g_src
                if (k < N - 1) begin : g_live
                    localparam int SRC_SIDE = (k < s) ? k : k + 1;
                    localparam int SRC_TRK  = (i + k * TWIST) % W;
                    assign srcs[k] = side_in[SRC_SIDE*W + SRC_TRK];
                end else begin : g_tie
                    assign srcs[k] = 1'b0;
                end
            end

            assign sel              = active_q[OUT_IDX*F +: SEL_W];
            assign reg_en[OUT_IDX]  = active_q[OUT_IDX*F + SEL_W];
            assign mux_out[OUT_IDX] = srcs[sel];
        end
    end

    assign side_out  = (reg_en & pipe_q) | (~reg_en & mux_out);
    assign scan_out  = shadow_q[0];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_sb_generic_piped.sv
// Directed bench for sb_generic_piped at W=4, N=4, TWIST=1 (48 config bits, 3-bit fields).
// Side packing: left [3:0], right [7:4], top [11:8], bottom [15:12].
module tb_sb_generic_piped;

    logic        clk;
    logic        rst;
    logic [15:0] side_in;
    logic [15:0] side_out;
    logic        scan_in;
    logic        scan_en;
    logic        scan_out;
    logic        cfg_commit;
    logic        cfg_valid;
    logic        cfg_err;

    int checks;
    int passes;

    sb_generic_piped #(
        .CHANNEL_ONEWAY_WIDTH(4),
        .NUM_SIDES           (4),
        .TWIST               (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .side_in   (side_in),
        .side_out  (side_out),
        .scan_in   (scan_in),
        .scan_en   (scan_en),
        .scan_out  (scan_out),
        .cfg_commit(cfg_commit),
        .cfg_valid (cfg_valid),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shifts bits lo..hi of v, lowest index first; returns at 1 time unit after the last edge.
    task automatic shift_bits(input logic [47:0] v, input int lo, input int hi);
        logic [47:0] sh;
        sh = v >> lo;
        for (int i = lo; i <= hi; i++) begin
            scan_in = sh[0];
            scan_en = 1'b1;
            sh      = sh >> 1;
            @(posedge clk);
            #1;
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
    endtask

    logic [15:0] t4_pat [5];
    logic        t4_exp5[5];
    logic [47:0] pat;

    initial begin
        checks     = 0;
        passes     = 0;
        rst        = 1'b1;
        scan_in    = 1'b0;
        scan_en    = 1'b0;
        cfg_commit = 1'b0;
        side_in    = 16'hF0A0;
        t4_pat     = '{16'hFFFF, 16'h0000, 16'hA5A5, 16'h5A5A, 16'h8001};
        t4_exp5    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // 1: reset state, select 0 everywhere, combinational path
        #2;
        check("rst_side_out", side_out, 16'h000A);
        check("rst_valid", cfg_valid, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_scan_out", scan_out, 1'b0);
        side_in = 16'hF050;
        #1;
        check("rst_comb_follow", side_out, 16'h0005);
        side_in = 16'hF0A0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 2: field 0 = 001 -> left[0] from top[1], combinational
        shift_bits(48'h1, 0, 47);
        commit();
        check("t2_valid", cfg_valid, 1'b1);
        check("t2_err", cfg_err, 1'b0);
        #1;
        check("t2_top1_lo", side_out, 16'h000A);
        side_in = 16'hF2A0;
        #1;
        check("t2_top1_hi", side_out, 16'h000B);

        // 3: field 0 = 101 -> same source, one-cycle latency
        shift_bits(48'h5, 0, 0);
        check("t3_valid_clr", cfg_valid, 1'b0);
        shift_bits(48'h5, 1, 47);
        commit();
        check("t3_valid", cfg_valid, 1'b1);
        side_in = 16'hF0A0;
        @(posedge clk);
        #1;
        check("t3_settle_lo", side_out[0], 1'b0);
        side_in = 16'hF2A0;
        #1;
        check("t3_hold_old_lo", side_out[0], 1'b0);
        @(posedge clk);
        #1;
        check("t3_rise_late", side_out[0], 1'b1);
        side_in = 16'hF0A0;
        #1;
        check("t3_hold_old_hi", side_out[0], 1'b1);
        @(posedge clk);
        #1;
        check("t3_fall_late", side_out[0], 1'b0);

        // 4: field 0 = 011 (tie-off); field 5 = 010 (right[1] from bottom[3], twisted)
        shift_bits(48'h3 | (48'h2 << 15), 0, 47);
        commit();
        for (int p = 0; p < 5; p++) begin
            side_in = t4_pat[p];
            #1;
            check("t4_tieoff", side_out[0], 1'b0);
            check("t4_twist_src", side_out[5], t4_exp5[p]);
        end

        // 5: short load rejected, then a full load accepted
        shift_bits(48'h1, 0, 46);
        commit();
        check("t5_err_set", cfg_err, 1'b1);
        check("t5_valid_kept", cfg_valid, 1'b0);
        side_in = 16'hFFFF;
        #1;
        check("t5_old_tieoff", side_out[0], 1'b0);
        check("t5_old_twist", side_out[5], 1'b1);
        shift_bits(48'h1, 0, 47);
        commit();
        check("t5_valid_new", cfg_valid, 1'b1);
        check("t5_err_sticky", cfg_err, 1'b1);
        side_in = 16'h0200;
        #1;
        check("t5_new_route", side_out, 16'h0001);

        // 6: scan-out readback, then async reset mid-shift
        side_in = 16'hFFA3;
        pat     = 48'h5555_5555_5555;
        shift_bits(pat, 0, 47);
        for (int j = 0; j < 48; j++) begin
            scan_in = 1'b1;
            scan_en = 1'b1;
            #1;
            check("t6_readback", scan_out, pat[0]);
            pat = pat >> 1;
            @(posedge clk);
            #1;
        end
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
        end
        check("t6_pre_rst_route", side_out, 16'h333B);
        check("t6_pre_rst_scan", scan_out, 1'b1);
        check("t6_pre_rst_err", cfg_err, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_route", side_out, 16'h333A);
        check("t6_rst_scan", scan_out, 1'b0);
        check("t6_rst_valid", cfg_valid, 1'b0);
        check("t6_rst_err", cfg_err, 1'b0);
        scan_en = 1'b0;
        scan_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Zero-length commit after reset is rejected and leaves routing alone
        commit();
        check("zero_commit_err", cfg_err, 1'b1);
        check("zero_commit_valid", cfg_valid, 1'b0);
        check("zero_commit_route", side_out, 16'h333A);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sb_generic_piped.md
Name: sb_generic_piped

Overview:
- Parametrised successor to the fixed-topology T/edge switch blocks.
- N-sided routing switch (left/right/top/bottom), W tracks per direction, Wilton-style twist set by parameter.
- Per output track: select mux, constant-0 tie-off code, optional pipeline flop.
- Configuration is a double-buffered scan chain: shadow register shifts, active register loads on commit; bit-count checking flags valid or erroneous loads.

Parameters:
- CHANNEL_ONEWAY_WIDTH, 4, tracks per side per direction (W), >=1.
- NUM_SIDES, 4, number of sides, 2..4; side index 0=left, 1=right, 2=top, 3=bottom.
- TWIST, 1, track rotation between successive sources; 0 = disjoint topology.
- Derived: SEL_W = max(1, clog2(NUM_SIDES-1)); F = SEL_W+1; CFG_BITS = NUM_SIDES*W*F (default 48); CNT_W = clog2(CFG_BITS+2).

Ports:
- clk  in  1  clock, all flops rising edge.
- rst  in  1  asynchronous, active-high reset.
- side_in  in  NUM_SIDES*W  side s at [s*W +: W].
- side_out  out  NUM_SIDES*W  same packing.
- scan_in  in  1  config serial data.
- scan_en  in  1  shift enable.
- scan_out  out  1  chain output, shadow[0].
- cfg_commit  in  1  single-cycle pulse: copy shadow to active.
- cfg_valid  out  1  active config came from a full-length load.
- cfg_err  out  1  sticky: a commit was rejected.

Behaviour:
- Reset (async, rst=1): shadow, active, pipeline flops, count, cfg_valid, cfg_err all 0.
- Under reset, active=0 gives select 0, combinational path: side_out follows source k=0 immediately.
- Shift: on clk with scan_en=1, shadow <= {scan_in, shadow[CFG_BITS-1:1]}. scan_out = shadow[0] (registered, no combinational path from scan_in).
- Shifted bit count: increments on each shift, saturates at CFG_BITS+1.
- Shadow writes never disturb routing; only active drives muxes.
- Field layout: output n = s*W+i owns active[n*F +: F].
  - Low SEL_W bits = sel.
  - Top bit = reg_en.
  - First bit shifted in lands in bit 0 after CFG_BITS shifts.
- Source mapping for output (s,i): k = 0..NUM_SIDES-2 enumerates the other sides in ascending index, skipping s. Source k is side_in of the k-th other side, track (i + k*TWIST) mod W.
- sel >= NUM_SIDES-1 selects constant 0.
- reg_en=0: side_out bit is combinational mux output (0 latency).
- reg_en=1: side_out bit comes from a flop capturing the mux output every clk (1-cycle latency). The flop captures continuously regardless of reg_en, so switching reg_en never exposes a stale value older than one cycle.
- Commit state machine, states IDLE / SHIFTING / LOADED:
  - IDLE: after reset.
  - SHIFTING: entered on first scan_en shift; stays there while shifting.
  - cfg_commit with scan_en=0 and count==CFG_BITS: active <= shadow at that edge; count <= 0; cfg_valid <= 1; state goes to LOADED. Routing uses the new config from the next cycle.
  - cfg_commit with count != CFG_BITS (short, long, or zero): active unchanged; cfg_err <= 1; count <= 0; cfg_valid unchanged; state goes to IDLE.
  - cfg_commit with scan_en=1 in the same cycle: rejected as an error; the shift still occurs, and count restarts at 1.
  - First shift after LOADED: cfg_valid <= 0 (shadow now diverges); state goes to SHIFTING.
  - cfg_err clears only on rst.
- Reset mid-shift or mid-commit: everything returns to reset values asynchronously; a partial load is lost.

Test Plan:
1. Reset, W=4, N=4, TWIST=1, drive side_in: right=4'hA, top=4'h0, bottom=4'hF -> side_out left = 4'hA combinationally, cfg_valid=0, cfg_err=0, scan_out=0.
2. Shift 48 bits with only field 0 = 3'b001, then commit -> side_out[0] tracks top_in[1]. Toggling top_in[1] 0->1 makes side_out[0] go 1 in the same cycle. cfg_valid=1 next cycle.
3. Reload field 0 = 3'b101, commit, toggle top_in[1] -> side_out[0] follows exactly one clk later.
4. Field 0 = 3'b011 (sel 3) -> side_out[0] held 0 for all side_in patterns.
5. Shift 47 bits, commit -> active unchanged (previous routing intact), cfg_err=1, cfg_valid unchanged. Then 48 shifts + commit -> new config applied, cfg_err still 1.
6. Shift 48 bits 1010..., 48 more bits -> scan_out reproduces the first 48 bits in order. Assert rst at shift 20 -> all outputs and flags return to reset values immediately.
